id_stage: RTL
=============

Name: id_stage

Overview:
- Decode stage of the 5-stage LoongArch pipeline; consumes the fetch stage's instruction/PC handshake and feeds the execute stage.
- Latches the fetched instruction and drives the two register-file read ports.
- Forwards results from EX/MEM/WB and stalls on a load-use hazard.
- Resolves branches and jumps, returns br_taken/br_target to fetch, and squashes the wrong-path instruction.

Parameters:
- None. All datapaths are fixed at 32 bits by the ISA.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
fs2ds_valid  in  1  fetch has an instruction for decode
ds_allowin  out  1  decode can accept an instruction this cycle
fs_pc  in  32  PC of the fetched instruction
inst  in  32  fetched instruction word
br_taken  out  1  redirect fetch this cycle
br_target  out  32  redirect address
rf_raddr1  out  5  regfile read address, source 1 (rj)
rf_raddr2  out  5  regfile read address, source 2 (rk or rd)
rf_rdata1  in  32  regfile read data, source 1
rf_rdata2  in  32  regfile read data, source 2
es_fwd_valid / ms_fwd_valid / ws_fwd_valid  in  1 each  stage holds a valid instruction
es_we / ms_we / ws_we  in  1 each  that instruction writes the GPR file
es_waddr / ms_waddr / ws_waddr  in  5 each  destination register
es_wdata / ms_wdata / ws_wdata  in  32 each  result value (es_wdata is meaningless when es_is_load)
es_is_load  in  1  EX instruction is a load
es_allowin  in  1  execute can accept
ds2es_valid  out  1  decode output is valid
ds_pc_o  out  32  PC passed to EX
ds_inst_o  out  32  instruction passed to EX
ds_src1  out  32  forwarded rj value
ds_src2  out  32  forwarded rk/rd value

Behaviour:
- Reset (async, resetn=0): ds_valid=0, ds_pc=0, ds_inst=0. Outputs follow: ds2es_valid=0, br_taken=0, ds_allowin=1.
- Handshake:
  - ds_allowin = ~ds_valid | (ds_ready_go & es_allowin).
  - ds2es_valid = ds_valid & ds_ready_go.
  - When ds_allowin: ds_valid <= fs2ds_valid & ~br_taken. If fs2ds_valid, ds_pc <= fs_pc and ds_inst <= inst.
  - When ds_allowin is 0, all state holds.
- Field decode:
  - op6 = inst[31:26], rj = [9:5], rk = [14:10], rd = [4:0].
  - offs16 = inst[25:10]; offs26 = {inst[9:0], inst[25:10]}.
- Source selection:
  - rf_raddr1 = rj.
  - rf_raddr2 = rd when op6 is 0x16 (beq) or 0x17 (bne), or inst[31:22] = 0x0A6 (st.w); otherwise rk.
  - src1 is used unless op6 is 0x14 (b) or 0x15 (bl).
  - src2 is used unless op6 is 0x13/0x14/0x15. The over-approximation is accepted; it only causes harmless extra stalls.
- Forwarding, per source, combinational:
  - Priority: ES, then MS, then WS, then regfile.
  - A stage hits when x_fwd_valid & x_we & x_waddr != 0 & x_waddr == source address.
  - Address 0 always yields 0.
- Load-use stall: ds_ready_go = 0 when a used source hits ES and es_is_load. Otherwise ds_ready_go = 1.
- Branch resolution (evaluated only when ds_valid & ds_ready_go):
  - 0x16 beq taken if src1 == src2.
  - 0x17 bne taken if src1 != src2.
  - 0x14 b and 0x15 bl always taken; target = ds_pc + sext({offs26, 2'b00}).
  - 0x13 jirl always taken; target = src1 + sext({offs16, 2'b00}).
  - beq/bne target = ds_pc + sext({offs16, 2'b00}).
  - All adds are 32-bit and wrap modulo 2^32.
- br_taken is asserted only when ds_valid & ds_ready_go & es_allowin & taken-condition, for exactly one cycle per branch.
- Wrong path: in the br_taken cycle the instruction arriving from fetch is wrong-path, so ds_valid loads 0 and the fetched word is discarded.
- Simultaneous events:
  - Stall plus branch: br_taken stays 0 until the stall clears.
  - es_allowin=0: branch not signalled and state holds.
- Reset mid-operation: all in-flight state is cleared immediately; no br_taken is emitted.
- ds_pc_o/ds_inst_o are the latched registers; ds_src1/ds_src2 are the forwarded values.

Test Plan:
- Reset released, fs2ds_valid=1, fs_pc=0x1c000000, es_allowin=1 -> ds2es_valid=1 the next cycle, ds_pc_o=0x1c000000, no br_taken.
- EX holds a non-load writing r5=0x11 and MS holds a write r5=0x22; decoded instruction reads rj=r5 -> ds_src1=0x11 (ES priority). EX write targets r0 -> r0 reads 0.
- EX holds a load to r7 and decode reads rk=r7 -> ds_ready_go=0, ds_allowin=0 for one cycle. Next cycle the load is in MS -> value forwarded from ms_wdata and the instruction issues.
- beq at pc 0x1c000010, offs16=0x0004, r4=r5=3 -> br_taken=1 for one cycle, br_target=0x1c000020, following fetched instruction squashed (ds2es_valid=0 next cycle). With r5=4 -> no branch, sequential flow.
- jirl rd=1, rj=r1=0x1c000100, offs16=0xFFFF -> br_target=0x1c0000FC. b with offs26=0x3FFFFFF at pc 0x1c000000 -> target 0x1bfffffc.
- es_allowin held 0 with a taken bne in decode -> br_taken stays 0 and state holds. Assert resetn=0 mid-stall -> ds2es_valid drops to 0 immediately.

Source files
------------

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage : decode stage of the 5-stage LoongArch pipeline.
//
// Latches one instruction from fetch and decodes its register fields. It drives
// the two register-file read ports and forwards in-flight results from
// EX/MEM/WB. It holds the instruction on a load-use hazard. Branches and jumps
// are resolved here, and fetch is redirected through br_taken/br_target.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   fs2ds_valid, fs_pc, inst     instruction handshake from fetch
//   ds_allowin                   decode can accept an instruction this cycle
//   br_taken, br_target          one-cycle fetch redirect and its address
//   rf_raddr1/2, rf_rdata1/2     register-file read ports (rj, rk-or-rd)
//   {es,ms,ws}_fwd_valid/_we/_waddr/_wdata
//                                result bypass from EX, MEM and WB
//   es_is_load                   EX holds a load (its es_wdata is not ready)
//   es_allowin                   execute can accept
//   ds2es_valid, ds_pc_o, ds_inst_o, ds_src1, ds_src2
//                                decoded instruction and operands to execute
// -----------------------------------------------------------------------------
module id_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fs2ds_valid,
  output logic        ds_allowin,
  input  logic [31:0] fs_pc,
  input  logic [31:0] inst,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        es_fwd_valid,
  input  logic        es_we,
  input  logic [4:0]  es_waddr,
  input  logic [31:0] es_wdata,
  input  logic        ms_fwd_valid,
  input  logic        ms_we,
  input  logic [4:0]  ms_waddr,
  input  logic [31:0] ms_wdata,
  input  logic        ws_fwd_valid,
  input  logic        ws_we,
  input  logic [4:0]  ws_waddr,
  input  logic [31:0] ws_wdata,
  input  logic        es_is_load,
  input  logic        es_allowin,
  output logic        ds2es_valid,
  output logic [31:0] ds_pc_o,
  output logic [31:0] ds_inst_o,
  output logic [31:0] ds_src1,
  output logic [31:0] ds_src2
);

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;
  localparam logic [9:0] OP_STW  = 10'h0A6;

  // A stage supplies a source when it holds a valid GPR write to that
  // register; r0 writes are never bypassed.
  function automatic logic fwd_hit(input logic       v,
                                   input logic       we,
                                   input logic [4:0] waddr,
                                   input logic [4:0] addr);
    return v & we & (waddr != 5'd0) & (waddr == addr);
  endfunction

  // Youngest producer wins: EX, then MEM, then WB, then the register file.
  function automatic logic [31:0] fwd_sel(input logic [4:0]  addr,
                                          input logic        es_h,
                                          input logic        ms_h,
                                          input logic        ws_h,
                                          input logic [31:0] es_d,
                                          input logic [31:0] ms_d,
                                          input logic [31:0] ws_d,
                                          input logic [31:0] rf_d);
    if (addr == 5'd0) return 32'd0;
    else if (es_h)    return es_d;
    else if (ms_h)    return ms_d;
    else if (ws_h)    return ws_d;
    else              return rf_d;
  endfunction

  logic        vld_p0;
  logic [31:0] pc_p0;
  logic [31:0] inst_p0;

  logic [5:0]  op6;
  logic [4:0]  rj, rk, rd;
  logic [15:0] offs16;
  logic [25:0] offs26;
  logic        is_beq, is_bne, is_b, is_bl, is_jirl, is_stw;
  logic        use_src1, use_src2;
  logic        es_hit1, ms_hit1, ws_hit1;
  logic        es_hit2, ms_hit2, ws_hit2;
  logic        ds_ready_go;
  logic        br_cond;
  logic signed [31:0] off16_s;
  logic signed [31:0] off26_s;

  // ---- stage p0: latched instruction from fetch ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p0  <= 1'b0;
      pc_p0   <= 32'd0;
      inst_p0 <= 32'd0;
    end else if (ds_allowin) begin
      // The word fetched while a redirect is signalled is wrong-path.
      vld_p0 <= fs2ds_valid & ~br_taken;
      if (fs2ds_valid) begin
        pc_p0   <= fs_pc;
        inst_p0 <= inst;
      end
    end
  end

  assign op6    = inst_p0[31:26];
  assign rj     = inst_p0[9:5];
  assign rk     = inst_p0[14:10];
  assign rd     = inst_p0[4:0];
  assign offs16 = inst_p0[25:10];
  assign offs26 = {inst_p0[9:0], inst_p0[25:10]};

  assign is_beq  = (op6 == OP_BEQ);
  assign is_bne  = (op6 == OP_BNE);
  assign is_b    = (op6 == OP_B);
  assign is_bl   = (op6 == OP_BL);
  assign is_jirl = (op6 == OP_JIRL);
  assign is_stw  = (inst_p0[31:22] == OP_STW);

  // Branch compares and stores read rd as their second operand.
  assign rf_raddr1 = rj;
  assign rf_raddr2 = (is_beq | is_bne | is_stw) ? rd : rk;

  // jirl counts as not using src2 even though other opcodes that ignore it
  // are treated as users; that only costs an occasional needless stall.
  assign use_src1 = ~(is_b | is_bl);
  assign use_src2 = ~(is_jirl | is_b | is_bl);

  assign es_hit1 = fwd_hit(es_fwd_valid, es_we, es_waddr, rf_raddr1);
  assign ms_hit1 = fwd_hit(ms_fwd_valid, ms_we, ms_waddr, rf_raddr1);
  assign ws_hit1 = fwd_hit(ws_fwd_valid, ws_we, ws_waddr, rf_raddr1);
  assign es_hit2 = fwd_hit(es_fwd_valid, es_we, es_waddr, rf_raddr2);
  assign ms_hit2 = fwd_hit(ms_fwd_valid, ms_we, ms_waddr, rf_raddr2);
  assign ws_hit2 = fwd_hit(ws_fwd_valid, ws_we, ws_waddr, rf_raddr2);

  assign ds_src1 = fwd_sel(rf_raddr1, es_hit1, ms_hit1, ws_hit1,
                           es_wdata, ms_wdata, ws_wdata, rf_rdata1);
  assign ds_src2 = fwd_sel(rf_raddr2, es_hit2, ms_hit2, ws_hit2,
                           es_wdata, ms_wdata, ws_wdata, rf_rdata2);

  // A load in EX has no data yet; wait one cycle for it to reach MEM.
  assign ds_ready_go = ~((use_src1 & es_hit1 & es_is_load) |
                         (use_src2 & es_hit2 & es_is_load));

  assign ds_allowin  = ~vld_p0 | (ds_ready_go & es_allowin);
  assign ds2es_valid = vld_p0 & ds_ready_go;

  assign off16_s = $signed({{14{offs16[15]}}, offs16, 2'b00});
  assign off26_s = $signed({{4{offs26[25]}}, offs26, 2'b00});

  always_comb begin
    br_cond   = 1'b0;
    br_target = pc_p0 + $unsigned(off16_s);
    case (op6)
      OP_BEQ:  br_cond = (ds_src1 == ds_src2);
      OP_BNE:  br_cond = (ds_src1 != ds_src2);
      OP_B,
      OP_BL: begin
        br_cond   = 1'b1;
        br_target = pc_p0 + $unsigned(off26_s);
      end
      OP_JIRL: begin
        br_cond   = 1'b1;
        br_target = ds_src1 + $unsigned(off16_s);
      end
      default: br_cond = 1'b0;
    endcase
  end

  // Redirect only when the branch actually moves into EX this cycle, so it
  // is raised once and never while stalled or blocked.
  assign br_taken = vld_p0 & ds_ready_go & es_allowin & br_cond;

  assign ds_pc_o   = pc_p0;
  assign ds_inst_o = inst_p0;

endmodule
